// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader: byte stream -> big-endian words -> instruction memory writes.
// Optional trailer checksum check enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
   parameter int ADDR_WIDTH = 9,
   parameter int BASE_ADDR  = 0,
   parameter int MAX_WORDS  = 128
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   output logic                  in_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic                  cpu_reset,
   output logic                  done,
   output logic                  error
);

   localparam int WC_W = $clog2(MAX_WORDS + 1);

   typedef enum logic [2:0] {
      S_HDR,
      S_LOAD,
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK,
`endif
      S_DONE,
      S_ERR
   } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam state_t S_AFTER = S_CHK;
   logic [31:0] csum;
`else
   localparam state_t S_AFTER = S_DONE;
`endif

   state_t            state, state_nxt;
   logic              live;
   logic [1:0]        bcnt;
   logic [WC_W-1:0]   wc;
   logic [WC_W-1:0]   n_len;
   logic [23:0]       shreg;
   logic              accept;
   logic              word_end;
   logic [31:0]       word4;

   assign accept   = in_valid && in_ready;
   assign word_end = accept && (bcnt == 2'd3);
   assign word4    = {shreg, in_data};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_HDR;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_HDR: begin
            if (word_end) begin
               if (word4 == 32'd0)                 state_nxt = S_AFTER;
               else if (word4 > 32'(MAX_WORDS))    state_nxt = S_ERR;
               else                                state_nxt = S_LOAD;
            end
         end
         // wc has already advanced during the write cycle of the last word
         S_LOAD: begin
            if (mem_we && (wc == n_len)) state_nxt = S_AFTER;
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CHK: begin
            if (word_end) state_nxt = (word4 == csum) ? S_DONE : S_ERR;
         end
`endif
         default: state_nxt = state;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      done      = 1'b0;
      error     = 1'b0;
      cpu_reset = 1'b1;
      case (state)
         S_HDR:  in_ready = live && !mem_we;
         S_LOAD: in_ready = live && !mem_we;
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CHK:  in_ready = live && !mem_we;
`endif
         S_DONE: begin
            done      = 1'b1;
            cpu_reset = 1'b0;
         end
         S_ERR:  error = 1'b1;
         default: in_ready = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         live      <= 1'b0;
         bcnt      <= 2'd0;
         wc        <= '0;
         n_len     <= '0;
         shreg     <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= ADDR_WIDTH'(BASE_ADDR);
         mem_wdata <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum      <= 32'd0;
`endif
      end else begin
         live   <= 1'b1;
         mem_we <= 1'b0;
         if (accept) begin
            shreg <= word4[23:0];
            bcnt  <= bcnt + 2'd1;
         end
         if (word_end) begin
            case (state)
               S_HDR: begin
                  wc    <= '0;
                  n_len <= word4[WC_W-1:0];
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum  <= word4;
`endif
               end
               S_LOAD: begin
                  mem_we    <= 1'b1;
                  mem_wdata <= word4;
                  mem_addr  <= ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'({wc, 2'b00});
                  wc        <= wc + WC_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum      <= csum + word4;
`endif
               end
               default: ;
            endcase
         end
      end
   end

endmodule
